// File: rtl/regfile_access_ctrl_if.sv
// Bundle of decode, issue, writeback and register-file signals for regfile_access_ctrl.
// master: the access controller; slave: its surroundings (decoder, execute, writeback, RF).
interface regfile_access_ctrl_if #(
    parameter int unsigned WORD_SIZE = 16
);
    // Decode
    logic                 dec_valid;
    logic                 dec_ready;
    logic [2:0]           dec_src1;
    logic [2:0]           dec_src2;
    logic [2:0]           dec_dst;
    logic                 dec_wen;
    // Issue
    logic                 iss_valid;
    logic                 iss_ready;
    logic [WORD_SIZE-1:0] iss_op_a;
    logic [WORD_SIZE-1:0] iss_op_b;
    logic [2:0]           iss_dst;
    logic                 iss_wen;
    // Writeback
    logic                 wb_valid;
    logic                 wb_ready;
    logic [2:0]           wb_addr;
    logic [WORD_SIZE-1:0] wb_data;
    // Register file
    logic [2:0]           rf_addr1;
    logic [2:0]           rf_addr2;
    logic                 rf_write_buff1;
    logic                 rf_write_buff2;
    logic                 rf_write;
    logic [2:0]           rf_addr_in;
    logic [WORD_SIZE-1:0] rf_data_in;
    logic [WORD_SIZE-1:0] rf_reg_buff1;
    logic [WORD_SIZE-1:0] rf_reg_buff2;

    modport master (
        input  dec_valid, dec_src1, dec_src2, dec_dst, dec_wen,
        output dec_ready,
        output iss_valid, iss_op_a, iss_op_b, iss_dst, iss_wen,
        input  iss_ready,
        input  wb_valid, wb_addr, wb_data,
        output wb_ready,
        output rf_addr1, rf_addr2, rf_write_buff1, rf_write_buff2,
        output rf_write, rf_addr_in, rf_data_in,
        input  rf_reg_buff1, rf_reg_buff2
    );

    modport slave (
        output dec_valid, dec_src1, dec_src2, dec_dst, dec_wen,
        input  dec_ready,
        input  iss_valid, iss_op_a, iss_op_b, iss_dst, iss_wen,
        output iss_ready,
        output wb_valid, wb_addr, wb_data,
        input  wb_ready,
        input  rf_addr1, rf_addr2, rf_write_buff1, rf_write_buff2,
        input  rf_write, rf_addr_in, rf_data_in,
        output rf_reg_buff1, rf_reg_buff2
    );
endinterface

// File: rtl/regfile_access_ctrl.sv
// Register-file access controller: scoreboarded operand read (IDLE->READ->CAPTURE->ISSUE)
// plus a 2-entry writeback FIFO that drains one entry per cycle into the register file.
// Optional feature macro REGFILE_BYPASS_EN: lets a decode whose pending source is the FIFO
// head being drained this cycle proceed, forwarding the head data into the captured operand.
module regfile_access_ctrl #(
    parameter int unsigned WORD_SIZE = 16,
    parameter int unsigned REG_NUM   = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    regfile_access_ctrl_if.master bus_io
);
    localparam int unsigned AddrW = 3;

    typedef enum logic [1:0] {StIdle, StRead, StCapture, StIssue} state_e;

    // One-hot scoreboard bit for a register address, index taken modulo REG_NUM.
    function automatic logic [REG_NUM-1:0] sb_mask(input logic [AddrW-1:0] a);
        return {{(REG_NUM-1){1'b0}}, 1'b1} << (32'(a) % REG_NUM);
    endfunction

    state_e               state_q;
    logic [AddrW-1:0]     src1_q, src2_q, dst_q;
    logic                 wen_q;
    logic                 rd_strobe_q;
    logic                 iss_valid_q;
    logic [WORD_SIZE-1:0] op_a_q, op_b_q;
    logic [REG_NUM-1:0]   sb_q, sb_d;

    logic [AddrW-1:0]     fifo_addr_q [2];
    logic [WORD_SIZE-1:0] fifo_data_q [2];
    logic                 wr_ptr_q, rd_ptr_q;
    logic [1:0]           count_q;

    logic                 fifo_push, fifo_pop;
    logic [AddrW-1:0]     head_addr;
    logic [WORD_SIZE-1:0] head_data;
    logic [REG_NUM-1:0]   drain_mask, blocked_src;
    logic                 src1_hit, src2_hit, dst_hit;
    logic                 dec_fire;
    logic [WORD_SIZE-1:0] cap_a, cap_b;

    assign fifo_pop   = (count_q != 2'd0);
    assign fifo_push  = bus_io.wb_valid & bus_io.wb_ready;
    assign head_addr  = fifo_addr_q[rd_ptr_q];
    assign head_data  = fifo_data_q[rd_ptr_q];
    assign drain_mask = fifo_pop ? sb_mask(head_addr) : '0;

`ifdef REGFILE_BYPASS_EN
    // A source cleared by this cycle's drain is not a hazard: its data is forwarded.
    assign blocked_src = sb_q & ~drain_mask;
`else
    assign blocked_src = sb_q;
`endif

    assign src1_hit = |(blocked_src & sb_mask(bus_io.dec_src1));
    assign src2_hit = |(blocked_src & sb_mask(bus_io.dec_src2));
    assign dst_hit  = bus_io.dec_wen & |(sb_q & sb_mask(bus_io.dec_dst));

    // rst_n gating keeps dec_ready low while reset is held.
    assign bus_io.dec_ready = rst_n & (state_q == StIdle) & ~src1_hit & ~src2_hit & ~dst_hit;
    assign dec_fire         = bus_io.dec_valid & bus_io.dec_ready;

    assign bus_io.wb_ready   = (count_q < 2'd2);
    assign bus_io.rf_write   = fifo_pop;
    assign bus_io.rf_addr_in = fifo_pop ? head_addr : '0;
    assign bus_io.rf_data_in = fifo_pop ? head_data : '0;

    assign bus_io.rf_addr1       = src1_q;
    assign bus_io.rf_addr2       = src2_q;
    assign bus_io.rf_write_buff1 = rd_strobe_q;
    assign bus_io.rf_write_buff2 = rd_strobe_q;

    assign bus_io.iss_valid = iss_valid_q;
    assign bus_io.iss_op_a  = op_a_q;
    assign bus_io.iss_op_b  = op_b_q;
    assign bus_io.iss_dst   = dst_q;
    assign bus_io.iss_wen   = wen_q;

`ifdef REGFILE_BYPASS_EN
    logic                 byp1_q, byp2_q;
    logic [WORD_SIZE-1:0] byp_data_q;

    // Remember at decode accept which operands must take the draining head data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byp1_q     <= 1'b0;
            byp2_q     <= 1'b0;
            byp_data_q <= '0;
        end else if (dec_fire) begin
            byp1_q     <= fifo_pop && (bus_io.dec_src1 == head_addr);
            byp2_q     <= fifo_pop && (bus_io.dec_src2 == head_addr);
            byp_data_q <= head_data;
        end
    end

    assign cap_a = byp1_q ? byp_data_q : bus_io.rf_reg_buff1;
    assign cap_b = byp2_q ? byp_data_q : bus_io.rf_reg_buff2;
`else
    assign cap_a = bus_io.rf_reg_buff1;
    assign cap_b = bus_io.rf_reg_buff2;
`endif

    // Scoreboard next state: drain clears, issue handshake sets (set wins on the same bit).
    always_comb begin
        sb_d = sb_q & ~drain_mask;
        if (state_q == StIssue && bus_io.iss_ready && wen_q) begin
            sb_d = sb_d | sb_mask(dst_q);
        end
    end

    // Scoreboard register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sb_q <= '0;
        else        sb_q <= sb_d;
    end

    // Access FSM with registered strobe/issue outputs; iss_valid rises on the third edge
    // counting the decode-accept edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            src1_q      <= '0;
            src2_q      <= '0;
            dst_q       <= '0;
            wen_q       <= 1'b0;
            rd_strobe_q <= 1'b0;
            iss_valid_q <= 1'b0;
            op_a_q      <= '0;
            op_b_q      <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (dec_fire) begin
                        src1_q      <= bus_io.dec_src1;
                        src2_q      <= bus_io.dec_src2;
                        dst_q       <= bus_io.dec_dst;
                        wen_q       <= bus_io.dec_wen;
                        rd_strobe_q <= 1'b1;
                        state_q     <= StRead;
                    end
                end
                StRead: begin
                    rd_strobe_q <= 1'b0;
                    state_q     <= StCapture;
                end
                StCapture: begin
                    op_a_q      <= cap_a;
                    op_b_q      <= cap_b;
                    iss_valid_q <= 1'b1;
                    state_q     <= StIssue;
                end
                StIssue: begin
                    if (bus_io.iss_ready) begin
                        iss_valid_q <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Writeback FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (fifo_push) wr_ptr_q <= ~wr_ptr_q;
            if (fifo_pop)  rd_ptr_q <= ~rd_ptr_q;
            count_q <= count_q + {1'b0, fifo_push} - {1'b0, fifo_pop};
        end
    end

    // Writeback FIFO storage; contents are only observed while count is non-zero.
    always_ff @(posedge clk) begin
        if (fifo_push) begin
            fifo_addr_q[wr_ptr_q] <= bus_io.wb_addr;
            fifo_data_q[wr_ptr_q] <= bus_io.wb_data;
        end
    end
endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Directed self-checking bench for regfile_access_ctrl with a small register-file model.
module tb_regfile_access_ctrl;
    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    always #5 clk = ~clk;

    regfile_access_ctrl_if #(.WORD_SIZE(16)) bus ();

    regfile_access_ctrl #(
        .WORD_SIZE (16),
        .REG_NUM   (8)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_io (bus.master)
    );

    // Register file model: buffered reads on write_buff strobes, writes on rf_write.
    logic [15:0] regs [8] = '{16'h0A00, 16'h0A01, 16'h0011, 16'h0022,
                              16'h0A04, 16'h0A05, 16'h0A06, 16'h0A07};

    always @(posedge clk) begin
        if (bus.rf_write_buff1) bus.rf_reg_buff1 <= regs[bus.rf_addr1];
        if (bus.rf_write_buff2) bus.rf_reg_buff2 <= regs[bus.rf_addr2];
        if (bus.rf_write)       regs[bus.rf_addr_in] <= bus.rf_data_in;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    endtask

    task automatic set_dec(input logic v, input logic [2:0] s1, s2, d, input logic w);
        bus.dec_valid = v;
        bus.dec_src1  = s1;
        bus.dec_src2  = s2;
        bus.dec_dst   = d;
        bus.dec_wen   = w;
    endtask

    // Full decode->issue transaction; iss_ready is held low for 'stall' extra cycles.
    task automatic run_issue(input logic [2:0] s1, s2, d, input logic w,
                             input logic [15:0] ea, eb, input int stall, input string tag);
        int unsigned waited = 0;
        @(negedge clk);
        set_dec(1'b1, s1, s2, d, w);
        #1;
        while (!bus.dec_ready && waited < 20) begin
            @(negedge clk);
            #1;
            waited++;
        end
        check({tag, "_dec_ready"}, 32'(bus.dec_ready), 1);
        @(negedge clk);
        set_dec(1'b0, 3'd0, 3'd0, 3'd0, 1'b0);
        #1;
        check({tag, "_read_strobe"}, 32'(bus.rf_write_buff1), 1);
        check({tag, "_rf_addr1"}, 32'(bus.rf_addr1), 32'(s1));
        check({tag, "_rf_addr2"}, 32'(bus.rf_addr2), 32'(s2));
        check({tag, "_valid_read"}, 32'(bus.iss_valid), 0);
        @(negedge clk);
        #1;
        check({tag, "_valid_capture"}, 32'(bus.iss_valid), 0);
        check({tag, "_strobe_off"}, 32'(bus.rf_write_buff1), 0);
        @(negedge clk);
        #1;
        check({tag, "_valid"}, 32'(bus.iss_valid), 1);
        check({tag, "_op_a"}, 32'(bus.iss_op_a), 32'(ea));
        check({tag, "_op_b"}, 32'(bus.iss_op_b), 32'(eb));
        check({tag, "_dst"}, 32'(bus.iss_dst), 32'(d));
        check({tag, "_wen"}, 32'(bus.iss_wen), 32'(w));
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            #1;
            check({tag, "_stall_valid"}, 32'(bus.iss_valid), 1);
            check({tag, "_stall_op_a"}, 32'(bus.iss_op_a), 32'(ea));
            check({tag, "_stall_op_b"}, 32'(bus.iss_op_b), 32'(eb));
            check({tag, "_stall_dec_ready"}, 32'(bus.dec_ready), 0);
        end
        bus.iss_ready = 1'b1;
        @(negedge clk);
        bus.iss_ready = 1'b0;
        #1;
        check({tag, "_valid_done"}, 32'(bus.iss_valid), 0);
    endtask

    // Source 'a' is pending; its writeback arrives and the decode waits on the drain.
    task automatic pend_case(input logic [2:0] a, input logic [15:0] dat, input logic [15:0] eb,
                             input string tag);
        @(negedge clk);
        set_dec(1'b1, a, 3'd0, 3'd0, 1'b0);
        bus.wb_valid = 1'b1;
        bus.wb_addr  = a;
        bus.wb_data  = dat;
        #1;
        check({tag, "_blocked"}, 32'(bus.dec_ready), 0);
        @(negedge clk);
        bus.wb_valid = 1'b0;
        #1;
        check({tag, "_rf_write"}, 32'(bus.rf_write), 1);
        check({tag, "_rf_addr_in"}, 32'(bus.rf_addr_in), 32'(a));
        check({tag, "_rf_data_in"}, 32'(bus.rf_data_in), 32'(dat));
`ifdef REGFILE_BYPASS_EN
        check({tag, "_ready_on_drain"}, 32'(bus.dec_ready), 1);
`else
        check({tag, "_ready_on_drain"}, 32'(bus.dec_ready), 0);
        @(negedge clk);
        #1;
        check({tag, "_ready_after_drain"}, 32'(bus.dec_ready), 1);
        check({tag, "_fifo_empty"}, 32'(bus.rf_write), 0);
`endif
        @(negedge clk);
        set_dec(1'b0, 3'd0, 3'd0, 3'd0, 1'b0);
        #1;
        check({tag, "_read_strobe"}, 32'(bus.rf_write_buff1), 1);
        @(negedge clk);
        @(negedge clk);
        #1;
        check({tag, "_valid"}, 32'(bus.iss_valid), 1);
        check({tag, "_op_a"}, 32'(bus.iss_op_a), 32'(dat));
        check({tag, "_op_b"}, 32'(bus.iss_op_b), 32'(eb));
        bus.iss_ready = 1'b1;
        @(negedge clk);
        bus.iss_ready = 1'b0;
    endtask

    initial begin
        set_dec(1'b0, 3'd0, 3'd0, 3'd0, 1'b0);
        bus.iss_ready = 1'b0;
        bus.wb_valid  = 1'b0;
        bus.wb_addr   = 3'd0;
        bus.wb_data   = 16'h0;

        // Reset state
        @(negedge clk);
        #1;
        check("rst_dec_ready", 32'(bus.dec_ready), 0);
        check("rst_wb_ready", 32'(bus.wb_ready), 1);
        check("rst_iss_valid", 32'(bus.iss_valid), 0);
        check("rst_rf_write", 32'(bus.rf_write), 0);
        check("rst_write_buff", 32'(bus.rf_write_buff1), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic issue with a 5-cycle iss_ready stall; sets scoreboard[4]
        run_issue(3'd2, 3'd3, 3'd4, 1'b1, 16'h0011, 16'h0022, 5, "basic");

        // R4 pending until its writeback drains
        pend_case(3'd4, 16'hBEEF, 16'h0A00, "pend4");

        // Make R5 pending, then the drain/bypass case on R5
        run_issue(3'd0, 3'd1, 3'd5, 1'b1, 16'h0A00, 16'h0A01, 0, "set5");
        pend_case(3'd5, 16'h1234, 16'h0A00, "pend5");

        // Three back-to-back writebacks
        @(negedge clk);
        bus.wb_valid = 1'b1; bus.wb_addr = 3'd1; bus.wb_data = 16'h1111;
        #1;
        check("wb1_ready", 32'(bus.wb_ready), 1);
        check("wb1_no_write", 32'(bus.rf_write), 0);
        @(negedge clk);
        bus.wb_addr = 3'd2; bus.wb_data = 16'h2222;
        #1;
        check("wb2_ready", 32'(bus.wb_ready), 1);
        check("wb2_write", 32'(bus.rf_write), 1);
        check("wb2_addr", 32'(bus.rf_addr_in), 1);
        check("wb2_data", 32'(bus.rf_data_in), 32'h1111);
        @(negedge clk);
        bus.wb_addr = 3'd3; bus.wb_data = 16'h3333;
        #1;
        check("wb3_ready", 32'(bus.wb_ready), 1);
        check("wb3_write", 32'(bus.rf_write), 1);
        check("wb3_addr", 32'(bus.rf_addr_in), 2);
        @(negedge clk);
        bus.wb_valid = 1'b0;
        #1;
        check("wb4_write", 32'(bus.rf_write), 1);
        check("wb4_addr", 32'(bus.rf_addr_in), 3);
        check("wb4_data", 32'(bus.rf_data_in), 32'h3333);
        @(negedge clk);
        #1;
        check("wb_drained", 32'(bus.rf_write), 0);
        run_issue(3'd1, 3'd3, 3'd0, 1'b0, 16'h1111, 16'h3333, 0, "rd13");
        run_issue(3'd4, 3'd5, 3'd0, 1'b0, 16'hBEEF, 16'h1234, 0, "rd45");

        // Reset pulse in CAPTURE with one FIFO entry pending
        @(negedge clk);
        set_dec(1'b1, 3'd2, 3'd3, 3'd6, 1'b1);
        #1;
        check("mid_dec_ready", 32'(bus.dec_ready), 1);
        @(negedge clk);
        set_dec(1'b0, 3'd0, 3'd0, 3'd0, 1'b0);
        bus.wb_valid = 1'b1; bus.wb_addr = 3'd7; bus.wb_data = 16'h7777;
        #1;
        check("mid_read_strobe", 32'(bus.rf_write_buff1), 1);
        @(negedge clk);
        bus.wb_valid = 1'b0;
        #1;
        check("mid_capture_write", 32'(bus.rf_write), 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_iss_valid", 32'(bus.iss_valid), 0);
        check("mid_rst_rf_write", 32'(bus.rf_write), 0);
        check("mid_rst_strobe", 32'(bus.rf_write_buff1), 0);
        check("mid_rst_dec_ready", 32'(bus.dec_ready), 0);
        check("mid_rst_wb_ready", 32'(bus.wb_ready), 1);
        check("mid_rst_op_a", 32'(bus.iss_op_a), 0);
        check("mid_rst_rf_addr_in", 32'(bus.rf_addr_in), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check("post_rst_rf_write", 32'(bus.rf_write), 0);
            check("post_rst_iss_valid", 32'(bus.iss_valid), 0);
        end
        // R7 never written, scoreboard[6] never set
        run_issue(3'd7, 3'd6, 3'd6, 1'b0, 16'h0A07, 16'h0A06, 0, "post_rst");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
